// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-port arbiter in front of a single-ported data memory with asynchronous
// read. Each access runs IDLE -> ACCESS -> ACK, so latency is fixed: a request
// sampled in IDLE on edge k produces its ack pulse two edges later.
//
// Configuration macro: DMEM_ARB_RR_EN
//   defined   : round-robin on ties (the requester other than last_owner wins;
//               requester 0 wins the first tie after reset)
//   undefined : fixed priority, req0 always wins; no last_owner state
//
// Ports
//   CLK, RSTn            clock (posedge) and asynchronous active-low reset
//   req0/req1            access request per requester
//   we0/we1              1 = write, 0 = read
//   adrs0/adrs1          word address
//   wd0/wd1              write data
//   ack0/ack1            one-cycle completion pulse
//   rd0/rd1              registered read data, valid while ackN is high
//   memWE                write enable to the data memory (high only in ACCESS)
//   memAdrs, memWD       address / write data to the data memory
//   memRD                asynchronous read data from the data memory
//   busy                 high whenever the FSM is not IDLE
//   state_dbg            current FSM state, for observation only
//
// Handshake: a requester raises reqN with weN/adrsN/wdN stable and keeps them
// stable until it samples ackN high; it drops reqN on that same edge. A reqN
// still high in IDLE afterwards is a fresh request. Requests seen while busy
// simply wait for the next IDLE cycle.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int dataWidth = 32
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [dataWidth-1:0] adrs0,
  input  logic [dataWidth-1:0] adrs1,
  input  logic [dataWidth-1:0] wd0,
  input  logic [dataWidth-1:0] wd1,
  output logic                 ack0,
  output logic                 ack1,
  output logic [dataWidth-1:0] rd0,
  output logic [dataWidth-1:0] rd1,
  output logic                 memWE,
  output logic [dataWidth-1:0] memAdrs,
  output logic [dataWidth-1:0] memWD,
  input  logic [dataWidth-1:0] memRD,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic owner;     // requester currently being served
  logic owner_we;  // latched write flag of the owner
  logic grant;     // arbitration winner among the live requests
  logic start;

  assign start = req0 | req1;

`ifdef DMEM_ARB_RR_EN
  logic last_owner;

  // On a tie the requester that was not served last wins.
  assign grant = (req0 && req1) ? ~last_owner : req1;

  // Reset value 1 makes requester 0 the winner of the first tie.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      last_owner <= 1'b1;
    end else if (state == IDLE && start) begin
      last_owner <= grant;
    end
  end
`else
  // Fixed priority: requester 1 wins only when requester 0 is idle.
  assign grant = req1 & ~req0;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACCESS;
      ACCESS:  state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // The winner's address/data are captured on entry to ACCESS. Requesters hold
  // them stable, so the registered copy equals the owner's live inputs during
  // ACCESS, and it naturally holds its last value afterwards.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      owner    <= 1'b0;
      owner_we <= 1'b0;
      memAdrs  <= '0;
      memWD    <= '0;
      rd0      <= '0;
      rd1      <= '0;
    end else begin
      if (state == IDLE && start) begin
        owner    <= grant;
        owner_we <= grant ? we1 : we0;
        memAdrs  <= grant ? adrs1 : adrs0;
        memWD    <= grant ? wd1 : wd0;
      end
      // Read data is captured on the edge that ends ACCESS; writes leave rdN alone.
      if (state == ACCESS && !owner_we) begin
        if (owner) begin
          rd1 <= memRD;
        end else begin
          rd0 <= memRD;
        end
      end
    end
  end

  // memWE decodes straight from state so an asynchronous reset during ACCESS
  // drops it immediately and the write never commits.
  assign memWE     = (state == ACCESS) && owner_we;
  assign ack0      = (state == ACK) && !owner;
  assign ack1      = (state == ACK) && owner;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Bench for dmem_arbiter with a 16-word behavioural data memory (asynchronous
// read, write on posedge). Stimulus tasks push the expected ack (port, cycle,
// rd0, rd1) into exp_q; a monitor process pops and compares on every ack.
// Build with or without DMEM_ARB_RR_EN to match the design build.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int W = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic         CLK  = 1'b0;
  logic         RSTn = 1'b0;
  logic         req0 = 1'b0;
  logic         req1 = 1'b0;
  logic         we0  = 1'b0;
  logic         we1  = 1'b0;
  logic [W-1:0] adrs0 = '0;
  logic [W-1:0] adrs1 = '0;
  logic [W-1:0] wd0   = '0;
  logic [W-1:0] wd1   = '0;
  logic         ack0, ack1, memWE, busy;
  logic [W-1:0] rd0, rd1, memAdrs, memWD, memRD;
  logic [1:0]   state_dbg;

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  dmem_arbiter #(.dataWidth(W)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .adrs0(adrs0), .adrs1(adrs1), .wd0(wd0), .wd1(wd1),
    .ack0(ack0), .ack1(ack1), .rd0(rd0), .rd1(rd1),
    .memWE(memWE), .memAdrs(memAdrs), .memWD(memWD), .memRD(memRD),
    .busy(busy), .state_dbg(state_dbg)
  );

  // Data memory: word i starts as 0x100+i, except word 3 = 0x0000000A.
  logic [W-1:0] mem [0:15];
  logic         mem_loaded = 1'b0;
  assign memRD = mem[memAdrs[3:0]];

  always @(posedge CLK) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h100 + i;
      mem[3]     <= 32'h0000_000A;
      mem_loaded <= 1'b1;
    end else if (memWE) begin
      mem[memAdrs[3:0]] <= memWD;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic         port;
    logic [31:0]  ack_cyc;
    logic [W-1:0] rd0;
    logic [W-1:0] rd1;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] mem_m [0:15];
  logic [W-1:0] rd0_m;
  logic [W-1:0] rd1_m;
  int           checks   = 0;
  int           failures = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    rd0_m = '0;
    rd1_m = '0;
  endtask

  task automatic expect_ack(input logic port, input logic we, input logic [W-1:0] adrs,
                            input logic [W-1:0] wd, input int ack_cyc);
    exp_t e;
    if (we) mem_m[adrs[3:0]] = wd;
    else if (port) rd1_m = mem_m[adrs[3:0]];
    else rd0_m = mem_m[adrs[3:0]];
    e.port    = port;
    e.ack_cyc = ack_cyc;
    e.rd0     = rd0_m;
    e.rd1     = rd1_m;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge CLK);
      if (ack0 || ack1) begin
        chk("ack_exclusive", {31'b0, ack0 & ack1}, '0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack: ack0=%b ack1=%b at cyc %0d, expected no ack", ack0, ack1, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("ack_port", {31'b0, ack1}, {31'b0, e.port});
          chk("ack_cycle", cyc, e.ack_cyc);
          chk("rd0", rd0, e.rd0);
          chk("rd1", rd1, e.rd1);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic set_port(input logic port, input logic req, input logic we,
                          input logic [W-1:0] adrs, input logic [W-1:0] wd);
    if (port) begin
      req1 = req; we1 = we; adrs1 = adrs; wd1 = wd;
    end else begin
      req0 = req; we0 = we; adrs0 = adrs; wd0 = wd;
    end
  endtask

  // One access on an idle DUT, called at a negedge. Checks the memory-side
  // timing; the ack itself is checked by the monitor.
  task automatic single(input logic port, input logic we, input logic [W-1:0] adrs,
                        input logic [W-1:0] wd);
    int c;
    c = cyc;
    expect_ack(port, we, adrs, wd, c + 2);
    set_port(port, 1'b1, we, adrs, wd);
    @(negedge CLK);  // ACCESS
    chk("access_memWE", {31'b0, memWE}, {31'b0, we});
    chk("access_memAdrs", memAdrs, adrs);
    chk("access_memWD", memWD, wd);
    chk("access_busy", {31'b0, busy}, 1);
    @(negedge CLK);  // ACK
    chk("ack_memWE", {31'b0, memWE}, '0);
    chk("ack_busy", {31'b0, busy}, 1);
    set_port(port, 1'b0, we, adrs, wd);
    @(negedge CLK);  // IDLE
    chk("idle_busy", {31'b0, busy}, '0);
    chk("idle_memAdrs_hold", memAdrs, adrs);
    chk("idle_memWE", {31'b0, memWE}, '0);
  endtask

  // Raise a request after 'delay' negedges and hold it until its ack (bounded).
  task automatic run_req(input logic port, input logic we, input logic [W-1:0] adrs,
                         input logic [W-1:0] wd, input int delay);
    bit got;
    got = 1'b0;
    repeat (delay) @(negedge CLK);
    set_port(port, 1'b1, we, adrs, wd);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (port ? ack1 : ack0) begin
        got = 1'b1;
        break;
      end
    end
    set_port(port, 1'b0, we, adrs, wd);
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL req_timeout: port %0d got no ack within 20 cycles, expected one", port);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int c;
    logic p;
    for (int i = 0; i < 16; i++) mem_m[i] = 32'h100 + i;
    mem_m[3] = 32'h0000_000A;
    model_reset();

    fork
      monitor();
      begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset values
    repeat (2) @(negedge CLK);
    chk("rst_ack0", {31'b0, ack0}, '0);
    chk("rst_ack1", {31'b0, ack1}, '0);
    chk("rst_memWE", {31'b0, memWE}, '0);
    chk("rst_busy", {31'b0, busy}, '0);
    chk("rst_rd0", rd0, '0);
    chk("rst_rd1", rd1, '0);
    chk("rst_memAdrs", memAdrs, '0);
    chk("rst_memWD", memWD, '0);
    chk("rst_state", {30'b0, state_dbg}, '0);
    RSTn = 1'b1;
    @(negedge CLK);

    // Single write, read-back on the other port, reads, write leaves rd alone
    single(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF);
    single(1'b1, 1'b0, 32'd5, '0);
    single(1'b0, 1'b0, 32'd4, '0);
    single(1'b1, 1'b0, 32'd3, '0);
    single(1'b1, 1'b1, 32'd6, 32'h0000_0055);

    // Late request: req1 rises while the req0 write to address 7 is in ACCESS
    c = cyc;
    expect_ack(1'b0, 1'b1, 32'd7, 32'hCAFE_F00D, c + 2);
    expect_ack(1'b1, 1'b0, 32'd7, '0, c + 5);
    fork
      run_req(1'b0, 1'b1, 32'd7, 32'hCAFE_F00D, 0);
      run_req(1'b1, 1'b0, 32'd7, '0, 1);
    join
    @(negedge CLK);

    // Reset in the middle of ACCESS of a write to address 9
    set_port(1'b0, 1'b1, 1'b1, 32'd9, 32'h1234_5678);
    @(negedge CLK);
    chk("abort_memWE_before", {31'b0, memWE}, 1);
    #2 RSTn = 1'b0;
    #1;
    chk("abort_memWE_async", {31'b0, memWE}, '0);
    chk("abort_busy", {31'b0, busy}, '0);
    chk("abort_ack0", {31'b0, ack0}, '0);
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    chk("abort_mem9_kept", mem[9], 32'h0000_0109);
    single(1'b1, 1'b0, 32'd9, '0);

    // Tie: both requests held continuously from reset
    RSTn = 1'b0;
    model_reset();
    set_port(1'b0, 1'b1, 1'b0, 32'd3, '0);
    set_port(1'b1, 1'b1, 1'b0, 32'd5, '0);
    @(negedge CLK);
    RSTn = 1'b1;
    c = cyc;
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
      p = i[0];
`else
      p = 1'b0;
`endif
      expect_ack(p, 1'b0, p ? 32'd5 : 32'd3, '0, c + 2 + 3 * i);
    end
    repeat (11) @(negedge CLK);
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (5) @(negedge CLK);

    chk("queue_empty", exp_q.size(), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter dataWidth, default 32, the width of every address and data bus.
REQ-002 The block SHALL have port CLK, input, 1 bit, the single clock; all state changes on posedge.
REQ-003 The block SHALL have port RSTn, input, 1 bit, an asynchronous active-low reset.
REQ-004 The block SHALL have ports req0 and req1, input, 1 bit each, access request from requester 0 or 1.
REQ-005 The block SHALL have ports we0 and we1, input, 1 bit each, 1 = write and 0 = read, held stable while reqN is high.
REQ-006 The block SHALL have ports adrs0 and adrs1, input, dataWidth bits each, word address, held stable while reqN is high.
REQ-007 The block SHALL have ports wd0 and wd1, input, dataWidth bits each, write data, held stable while reqN is high.
REQ-008 The block SHALL have ports ack0 and ack1, output, 1 bit each, a one-cycle completion pulse to the matching requester.
REQ-009 The block SHALL have ports rd0 and rd1, output, dataWidth bits each, registered read data, valid while ackN is high.
REQ-010 The block SHALL have port memWE, output, 1 bit, the write enable to the data memory.
REQ-011 The block SHALL have ports memAdrs and memWD, output, dataWidth bits each, address and write data to the data memory.
REQ-012 The block SHALL have port memRD, input, dataWidth bits, the asynchronous read data from the data memory.
REQ-013 The block SHALL have port busy, output, 1 bit, high whenever state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ACCESS and ACK.
REQ-015 In IDLE, when any reqN is high, the block SHALL latch the grant winner as owner and go to ACCESS.
REQ-016 In IDLE with no request pending, the block SHALL stay in IDLE.
REQ-017 ACCESS SHALL last exactly one cycle.
- memAdrs and memWD are driven from the owner.
- memWE equals the owner's weN.
- The memory write commits on the posedge ending ACCESS.
- On that edge memRD is captured into rdN of the owner.
REQ-018 ACK SHALL last exactly one cycle, with ackN of the owner high and every other ack low; the next state is IDLE.
REQ-019 Latency SHALL be fixed: for a req sampled high in IDLE on edge k, ack is high during cycle k+2.
REQ-020 A requester SHALL deassert reqN on the edge where it samples ackN high; a req still high in IDLE after that edge is treated as a new request.
REQ-021 Outside ACCESS:
- memWE is 0.
- memAdrs and memWD hold their last driven values.
REQ-022 A requester's rdN SHALL hold its value until that requester's next completed read; a write SHALL leave rdN unchanged.
REQ-023 A request arriving while busy is 1 SHALL wait and be arbitrated in the next IDLE cycle; it is never dropped.
REQ-024 ack0 and ack1 SHALL never be high in the same cycle.
REQ-025 Address values SHALL pass through unmodified; the block performs no range checking or wrap-around.

Reset
REQ-026 While RSTn is 0, independent of CLK, the block SHALL force these values:
- state is IDLE.
- ack0, ack1, memWE and busy are 0.
- rd0, rd1, memAdrs and memWD are 0.
- lastOwner is 1.
REQ-027 If reset asserts during ACCESS, memWE SHALL fall immediately and no write commits; the aborted requester receives no ack and must re-request after reset.

Configuration
REQ-028 With DMEM_ARB_RR_EN defined, arbitration SHALL be round-robin.
- When both requests are high, the requester other than lastOwner wins.
- lastOwner updates on entry to ACCESS.
- After reset, requester 0 wins the first tie.
REQ-029 Without DMEM_ARB_RR_EN, arbitration SHALL be fixed priority with req0 always winning, and lastOwner SHALL be omitted.

Verification
REQ-030 The bench SHALL cover a single write: req0=1, we0=1, adrs0=5, wd0=0xDEADBEEF.
- Required: memWE=1 only in cycle 1.
- Required: ack0 pulses in cycle 2.
- Required: a later read of adrs1=5 returns rd1=0xDEADBEEF.
REQ-031 The bench SHALL cover a read with memory[3]=0x0000000A: req1=1, we1=0, adrs1=3.
- Required: ack1 in cycle 2 with rd1=0x0000000A.
- Required: rd0 unchanged.
REQ-032 The bench SHALL cover a tie with both requests held continuously from reset.
- With RR: grants alternate 0,1,0,1, with acks 3 cycles apart.
- Without RR: only ack0 pulses, every 3 cycles.
REQ-033 The bench SHALL cover a late request: req1 rises while busy=1 during a req0 write to address 7.
- Required: req1 is served immediately after the ACK state, ack1 3 cycles after ack0.
- Required: the address 7 data is intact.
REQ-034 The bench SHALL cover reset during a write: RSTn=0 mid-ACCESS of a write of 0x12345678 to address 9.
- Required: memWE drops without waiting for a clock edge.
- Required: no ack is issued.
- Required: address 9 keeps its old value and busy=0.
